// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared widths, slot count and loader state encoding for the sorter front end
package sort_pkg;

    localparam int SORT_WIDTH = 4;
    localparam int NUM_SLOTS  = 4;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } load_state_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, stable-count debouncer and rising-edge strobe
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic             db_dly_q, db_dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        db_dly_d = db_q;
        db_d     = db_q;
        cnt_d    = '0;
        // A level change is accepted only after DB_CYCLES consecutive mismatching edges.
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
            cnt_q    <= cnt_d;
        end
    end

    assign btn_level = db_q;
    assign btn_rise  = db_q & ~db_dly_q;

endmodule

// File: rtl/sort_input_loader.sv
// rtl/sort_input_loader.sv - captures four debounced button-loaded values and holds them for the sorter
module sort_input_loader
    import sort_pkg::*;
#(
    parameter int WIDTH     = SORT_WIDTH,
    parameter int DB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_btn,
    input  logic             clr,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [2:0]       count,
    output logic             full,
    output logic             load_ack
);

    logic load_stb;
    logic btn_level;

    load_state_e      state_q, state_d;
    logic [WIDTH-1:0] slot_q [NUM_SLOTS];
    logic [WIDTH-1:0] slot_d [NUM_SLOTS];
    logic [2:0]       count_q, count_d;
    logic             full_q, full_d;
    logic             ack_q, ack_d;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (load_btn),
        .btn_level (btn_level),
        .btn_rise  (load_stb)
    );

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        count_d = count_q;
        full_d  = full_q;
        ack_d   = 1'b0;
        if (clr) begin
            state_d = ST_EMPTY;
            for (int i = 0; i < NUM_SLOTS; i++) slot_d[i] = '0;
            count_d = '0;
            full_d  = 1'b0;
        end else if (load_stb && state_q != ST_FULL) begin
            // The fill count doubles as the write pointer.
            slot_d[count_q[1:0]] = data_in;
            count_d = count_q + 3'd1;
            ack_d   = 1'b1;
            if (count_q == 3'(NUM_SLOTS - 1)) begin
                state_d = ST_FULL;
                full_d  = 1'b1;
            end else begin
                state_d = ST_FILLING;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            count_q <= count_d;
            full_q  <= full_d;
            ack_q   <= ack_d;
        end
    end

    assign A        = slot_q[0];
    assign B        = slot_q[1];
    assign C        = slot_q[2];
    assign D        = slot_q[3];
    assign count    = count_q;
    assign full     = full_q;
    assign load_ack = ack_q;

endmodule

// File: tb/tb_sort_input_loader.sv
// tb/tb_sort_input_loader.sv - directed and randomized checks of the loader against a slot-list model
module tb_sort_input_loader;

    localparam int W  = 4;
    localparam int DB = 4;
    // Raw press start to load_ack sample: capture edge is k+2+DB, k being the first sampling edge.
    localparam int ACK_TICK = DB + 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         load_btn = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] A, B, C, D;
    logic [2:0]   count;
    logic         full;
    logic         load_ack;

    sort_input_loader #(
        .WIDTH     (W),
        .DB_CYCLES (DB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .load_btn (load_btn),
        .clr      (clr),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .count    (count),
        .full     (full),
        .load_ack (load_ack)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    int           m_cnt;
    logic [W-1:0] m_slot [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_cnt = 0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".A"}, 32'(A), 32'(m_slot[0]));
        chk({tag, ".B"}, 32'(B), 32'(m_slot[1]));
        chk({tag, ".C"}, 32'(C), 32'(m_slot[2]));
        chk({tag, ".D"}, 32'(D), 32'(m_slot[3]));
        chk({tag, ".count"}, 32'(count), 32'(m_cnt));
        chk({tag, ".full"}, 32'(full), 32'(m_cnt == 4));
    endtask

    task automatic tick(input bit exp_ack);
        @(posedge clk);
        #1;
        chk("load_ack", 32'(load_ack), 32'(exp_ack));
    endtask

    task automatic press(input logic [W-1:0] val, input int hold, input bit clr_cap);
        bit cap;
        int n;
        cap = (hold >= DB) && !clr_cap && (m_cnt < 4);
        n   = ((hold > ACK_TICK) ? hold : ACK_TICK) + 8;
        data_in  = val;
        load_btn = 1'b1;
        for (int i = 1; i <= n; i++) begin
            if (clr_cap && i == ACK_TICK) clr = 1'b1;
            tick(cap && i == ACK_TICK);
            if (clr_cap && i == ACK_TICK) begin
                clr = 1'b0;
                model_clear();
            end
            if (cap && i == ACK_TICK) begin
                m_slot[m_cnt] = val;
                m_cnt++;
            end
            if (i == hold) load_btn = 1'b0;
        end
        check_all("press");
    endtask

    task automatic glitch(input int len);
        load_btn = 1'b1;
        for (int i = 0; i < len; i++) tick(1'b0);
        load_btn = 1'b0;
        for (int i = 0; i < 8; i++) tick(1'b0);
        check_all("glitch");
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick(1'b0);
        clr = 1'b0;
        model_clear();
        check_all("clr");
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.load_ack", 32'(load_ack), 32'd0);
        rst_n = 1'b1;
        tick(1'b0);

        press(4'd9, 8, 1'b0);
        press(4'd3, 8, 1'b0);
        press(4'd12, 8, 1'b0);
        press(4'd1, 8, 1'b0);
        press(4'd7, 8, 1'b0);
        do_clear();
        press(4'd5, 8, 1'b0);

        glitch(3);
        load_btn = 1'b1;
        tick(1'b0);
        load_btn = 1'b0;
        tick(1'b0);
        press(4'd6, 8, 1'b0);

        do_clear();
        press(4'd4, 8, 1'b1);

        press(4'd8, 6, 1'b0);
        press(4'd11, 6, 1'b0);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b0);
        press(4'd2, 6, 1'b0);
        press(4'd2, 6, 1'b0);
        press(4'd0, 6, 1'b0);
        press(4'd15, 6, 1'b0);

        for (int r = 0; r < 6; r++) begin
            do_clear();
            for (int p = 0; p < int'($urandom_range(1, 6)); p++) begin
                if ($urandom_range(0, 1) == 1) glitch(int'($urandom_range(1, DB - 1)));
                press(W'($urandom), int'($urandom_range(DB, 10)), $urandom_range(0, 7) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
